// File: rtl/mc8123_key_loader.sv
// MC8123 key loader: captures the 8 KB decryption key from the ioctl download stream
// into block RAM and serves it to the decrypt stage once a complete load has been checked.
module mc8123_key_loader #(
    parameter logic [24:0] KEY_BASE  = 25'h020000,
    parameter logic [7:0]  KEY_INDEX = 8'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [12:0] key_a,
    output logic [7:0]  key_d,
    output logic        key_valid,
    output logic        key_error,
    output logic [15:0] key_sum,
    output logic        cpu_wait
);

    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StReady, StError} state_e;

    localparam logic [13:0] KeySize = 14'd8192;
    localparam logic [25:0] KeyLast = {1'b0, KEY_BASE} + 26'd8191;

    state_e      state_q, state_d;
    logic        dl_q, dl_d;
    logic [13:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic [15:0] sum_q, sum_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        wait_q, wait_d;
    logic        rd_en_q, rd_en_d;
    logic [7:0]  rd_data_q;

    logic [7:0]  key_mem [0:8191];

    logic        dl_now, dl_start, dl_end;
    logic        in_window, wr_hit, ram_we, load_entry;
    logic [12:0] waddr;

    assign dl_now   = ioctl_download & (ioctl_index == KEY_INDEX);
    assign dl_start = dl_now & ~dl_q;
    assign dl_end   = ~dl_now & dl_q;

    assign in_window = ({1'b0, ioctl_addr} >= {1'b0, KEY_BASE}) &&
                       ({1'b0, ioctl_addr} <= KeyLast);
    assign wr_hit    = dl_now & ioctl_wr & in_window & (state_q == StLoad);
    assign ram_we    = wr_hit & (count_q != KeySize);
    // Only the low 13 bits of the offset matter once the address is inside the window.
    assign waddr     = ioctl_addr[12:0] - KEY_BASE[12:0];
    assign load_entry = dl_start && (state_q inside {StIdle, StReady, StError});

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            dl_q       <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sum_q      <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            wait_q     <= 1'b1;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= dl_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            wait_q     <= wait_d;
            rd_en_q    <= rd_en_d;
        end
    end

    // Key RAM: contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            key_mem[waddr] <= ioctl_dout;
        end
        rd_data_q <= key_mem[key_a];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (dl_start) state_d = StLoad;
            StLoad:  if (dl_end) state_d = StCheck;
            StCheck: state_d = ((count_q == KeySize) && !overflow_q) ? StReady : StError;
            StReady: if (dl_start) state_d = StLoad;
            StError: if (dl_start) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    // Load counters, checksum and overflow tracking.
    always_comb begin
        dl_d       = dl_now;
        count_d    = count_q;
        overflow_d = overflow_q;
        sum_d      = sum_q;
        if (load_entry) begin
            count_d    = '0;
            overflow_d = 1'b0;
            sum_d      = '0;
        end else if (wr_hit) begin
            if (count_q == KeySize) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 14'd1;
                sum_d   = sum_q + {8'h00, ioctl_dout};
            end
        end
    end

    // Registered outputs derived from the upcoming state.
    always_comb begin
        valid_d = (state_d == StReady);
        error_d = (state_d == StError);
        wait_d  = (state_d != StReady);
        rd_en_d = (state_q == StReady);
    end

    assign key_d     = rd_en_q ? rd_data_q : 8'hFF;
    assign key_valid = valid_q;
    assign key_error = error_q;
    assign key_sum   = sum_q;
    assign cpu_wait  = wait_q;

endmodule

// File: tb/tb_mc8123_key_loader.sv
// Directed bench for mc8123_key_loader: full, short and overflowing loads, address window,
// reload/reset behaviour and back-to-back key reads.
module tb_mc8123_key_loader;

    localparam logic [24:0] KB = 25'h020000;

    logic        clk;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [12:0] key_a;
    logic [7:0]  key_d;
    logic        key_valid;
    logic        key_error;
    logic [15:0] key_sum;
    logic        cpu_wait;

    int          total;
    int          bad;
    logic [15:0] exp_sum;
    logic [7:0]  pat_q;

    mc8123_key_loader #(
        .KEY_BASE  (KB),
        .KEY_INDEX (8'd0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .key_a          (key_a),
        .key_d          (key_d),
        .key_valid      (key_valid),
        .key_error      (key_error),
        .key_sum        (key_sum),
        .cpu_wait       (cpu_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dl_begin(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
        if (idx == 8'd0) exp_sum = 16'h0000;
    endtask

    // Writes n bytes to KEY_BASE + (i mod 8192) with data (i[7:0] ^ pat).
    task automatic load_key(input int n, input logic [7:0] pat);
        logic [12:0] a;
        for (int i = 0; i < n; i++) begin
            a          = i[12:0];
            ioctl_wr   = 1'b1;
            ioctl_addr = KB + {12'b0, a};
            ioctl_dout = a[7:0] ^ pat;
            if (i < 8192) exp_sum = exp_sum + {8'h00, ioctl_dout};
            tick();
        end
        ioctl_wr = 1'b0;
        pat_q    = pat;
    endtask

    task automatic dl_finish();
        ioctl_download = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++; if (key_d !== 8'hFF) begin bad++; $display("FAIL reset_key_d got=%h want=ff", key_d); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        total++; if (key_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", key_error); end
        total++; if (key_sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h want=0000", key_sum); end
        total++; if (cpu_wait !== 1'b1) begin bad++; $display("FAIL reset_wait got=%b want=1", cpu_wait); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        dl_begin(8'd0);
        load_key(8192, 8'h00);
        ioctl_download = 1'b0;
        tick();
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL full_valid_early got=%b want=0", key_valid); end
        tick();
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", key_valid); end
        total++; if (key_error !== 1'b0) begin bad++; $display("FAIL full_error got=%b want=0", key_error); end
        total++; if (cpu_wait !== 1'b0) begin bad++; $display("FAIL full_wait got=%b want=0", cpu_wait); end
        // sum(0..255) * 32 = 0xFF000, truncated to 16 bits
        total++; if (key_sum !== 16'hF000) begin bad++; $display("FAIL full_sum got=%h want=f000", key_sum); end
        key_a = 13'h0123;
        tick();
        total++; if (key_d !== 8'h23) begin bad++; $display("FAIL full_read got=%h want=23", key_d); end
    endtask

    task automatic test_short();
        dl_begin(8'd0);
        load_key(8191, 8'h00);
        dl_finish();
        total++; if (key_error !== 1'b1) begin bad++; $display("FAIL short_error got=%b want=1", key_error); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%b want=0", key_valid); end
        total++; if (cpu_wait !== 1'b1) begin bad++; $display("FAIL short_wait got=%b want=1", cpu_wait); end
        total++; if (key_sum !== exp_sum) begin bad++; $display("FAIL short_sum got=%h want=%h", key_sum, exp_sum); end
        key_a = 13'h0010;
        tick();
        total++; if (key_d !== 8'hFF) begin bad++; $display("FAIL short_key_d got=%h want=ff", key_d); end
    endtask

    task automatic test_overflow();
        dl_begin(8'd0);
        load_key(8193, 8'h00);
        dl_finish();
        total++; if (key_error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%b want=1", key_error); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ovf_valid got=%b want=0", key_valid); end
    endtask

    task automatic test_window();
        dl_begin(8'd0);
        // Out-of-window writes just below and just above the key range.
        ioctl_wr = 1'b1; ioctl_addr = KB - 25'd1; ioctl_dout = 8'hAA; tick();
        ioctl_addr = KB + 25'd8192; ioctl_dout = 8'hAB; tick();
        ioctl_wr = 1'b0;
        load_key(8192, 8'h00);
        ioctl_wr = 1'b1; ioctl_addr = KB + 25'd8192; ioctl_dout = 8'hAC; tick();
        ioctl_wr = 1'b0;
        dl_finish();
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL win_valid got=%b want=1", key_valid); end
        total++; if (key_sum !== 16'hF000) begin bad++; $display("FAIL win_sum got=%h want=f000", key_sum); end
        // A download on index 1 over the key window must not touch the key.
        dl_begin(8'd1);
        ioctl_wr = 1'b1; ioctl_addr = KB + 25'd5; ioctl_dout = 8'h5A; tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        tick();
        tick();
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL idx1_valid got=%b want=1", key_valid); end
        total++; if (key_sum !== 16'hF000) begin bad++; $display("FAIL idx1_sum got=%h want=f000", key_sum); end
        key_a = 13'h0005;
        tick();
        total++; if (key_d !== 8'h05) begin bad++; $display("FAIL idx1_read got=%h want=05", key_d); end
    endtask

    task automatic test_reload_reset();
        key_a          = 13'h0040;
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        tick();
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reload_valid got=%b want=0", key_valid); end
        total++; if (key_d !== 8'hFF) begin bad++; $display("FAIL reload_key_d got=%h want=ff", key_d); end
        total++; if (cpu_wait !== 1'b1) begin bad++; $display("FAIL reload_wait got=%b want=1", cpu_wait); end
        load_key(100, 8'h00);
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        tick();
        reset_n = 1'b1;
        total++; if (key_sum !== 16'h0000) begin bad++; $display("FAIL midrst_sum got=%h want=0000", key_sum); end
        total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", key_valid); end
        total++; if (key_error !== 1'b0) begin bad++; $display("FAIL midrst_error got=%b want=0", key_error); end
        total++; if (key_d !== 8'hFF) begin bad++; $display("FAIL midrst_key_d got=%h want=ff", key_d); end
        tick();
        tick();
        total++; if (key_error !== 1'b0) begin bad++; $display("FAIL idle_error got=%b want=0", key_error); end
        dl_begin(8'd0);
        load_key(8192, 8'h5C);
        dl_finish();
        total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL relo_valid got=%b want=1", key_valid); end
        total++; if (key_sum !== exp_sum) begin bad++; $display("FAIL relo_sum got=%h want=%h", key_sum, exp_sum); end
        key_a = 13'h0123;
        tick();
        total++; if (key_d !== 8'h7F) begin bad++; $display("FAIL relo_read got=%h want=7f", key_d); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] a;
        logic [7:0]  want;
        for (int i = 0; i < 40; i++) begin
            a     = i[12:0] + 13'd250;
            want  = a[7:0] ^ pat_q;
            key_a = a;
            tick();
            total++;
            if (key_d !== want) begin
                bad++;
                $display("FAIL b2b_read a=%h got=%h want=%h", a, key_d, want);
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        exp_sum        = 16'h0000;
        pat_q          = 8'h00;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        key_a          = '0;
        test_reset();
        test_full_load();
        test_short();
        test_overflow();
        test_window();
        test_reload_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
